// File: rtl/pipeline_pkg.sv
// Shared types for the destination-tracking pipeline: the per-stage control
// record carried from EX to WB and the bubble value that empties a stage.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  rf_en;
    logic                  load;
  } stage_ctrl_t;

  localparam stage_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/stage_ctrl_reg.sv
// One pipeline register for a stage_ctrl_t record; asserting bubble loads the
// empty record instead of d on the next rising edge.
module stage_ctrl_reg
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  stage_ctrl_t d,
  input  logic        bubble,
  output stage_ctrl_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BUBBLE;
    end else begin
      q <= bubble ? BUBBLE : d;
    end
  end

endmodule

// File: rtl/dest_tracking_pipeline.sv
// Carries destination register / write-enable / load flag from ID through
// EX, MEM and WB for the hazard/forwarding unit. Optional perf counters are
// enabled with `define DTP_PERF_COUNTERS_EN.
module dest_tracking_pipeline
  import pipeline_pkg::*;
#(
  parameter int STALL_CNT_W = 16,
  parameter int STALL_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ID_RD,
  input  logic                  ID_Register_File_Enable,
  input  logic                  ID_load_instr,
  input  logic                  ID_valid,
  input  logic                  IF_ID_LE,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] EX_RD,
  output logic [REG_ADDR_W-1:0] MEM_RD,
  output logic [REG_ADDR_W-1:0] WB_RD,
  output logic                  EX_Register_File_Enable,
  output logic                  MEM_Register_File_Enable,
  output logic                  WB_Register_File_Enable,
  output logic                  EX_load_instr,
  output logic                  stall_timeout,
  output logic                  protocol_err
`ifdef DTP_PERF_COUNTERS_EN
  ,
  output logic [31:0]           bubble_count,
  output logic [31:0]           retire_count
`endif
);

  localparam logic [STALL_CNT_W-1:0] LIMIT = STALL_CNT_W'(STALL_LIMIT);

  // Handshake: ID offers an instruction when ID_valid=1; it is taken into EX
  // on the edge where IF_ID_LE=1 and flush=0, otherwise EX receives a bubble
  // and the caller's IF/ID register keeps re-presenting the instruction.
  stage_ctrl_t ex_d, ex_q, mem_q, wb_q;
  logic        stall;
  logic        ex_bubble;

  assign stall     = ~IF_ID_LE;
  assign ex_bubble = stall | flush | ~ID_valid;

  always_comb begin
    ex_d       = BUBBLE;
    ex_d.rd    = ID_RD;
    // $zero writes travel with enable cleared so they are never forwarded.
    ex_d.rf_en = ID_Register_File_Enable && (ID_RD != '0);
    ex_d.load  = ID_load_instr;
  end

  stage_ctrl_reg u_ex_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (ex_d),
    .bubble (ex_bubble),
    .q      (ex_q)
  );

  stage_ctrl_reg u_mem_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (ex_q),
    .bubble (1'b0),
    .q      (mem_q)
  );

  stage_ctrl_reg u_wb_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (mem_q),
    .bubble (1'b0),
    .q      (wb_q)
  );

  assign EX_RD                    = ex_q.rd;
  assign EX_Register_File_Enable  = ex_q.rf_en;
  assign EX_load_instr            = ex_q.load;
  assign MEM_RD                   = mem_q.rd;
  assign MEM_Register_File_Enable = mem_q.rf_en;
  assign WB_RD                    = wb_q.rd;
  assign WB_Register_File_Enable  = wb_q.rf_en;

  logic unused_wb_load;
  assign unused_wb_load = wb_q.load;

  // Consecutive-stall watchdog; timeout is judged on the updated count so it
  // rises on the same edge the count reaches the limit.
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [STALL_CNT_W-1:0] stall_cnt_nxt;

  always_comb begin
    stall_cnt_nxt = '0;
    if (stall) begin
      stall_cnt_nxt = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt >= LIMIT) begin
        stall_timeout <= 1'b1;
      end
      // A stall is only legitimate while a load sits in EX.
      if (stall && !ex_q.load) begin
        protocol_err <= 1'b1;
      end
    end
  end

`ifdef DTP_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
      retire_count <= '0;
    end else begin
      if (stall || flush) begin
        bubble_count <= bubble_count + 32'd1;
      end
      if (wb_q.rf_en) begin
        retire_count <= retire_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dest_tracking_pipeline.sv
// Directed bench for dest_tracking_pipeline: hand-computed EX entries are
// queued and MEM/WB are checked against the entries queued one and two cycles earlier.
module tb_dest_tracking_pipeline;
  import pipeline_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [REG_ADDR_W-1:0] ID_RD;
  logic                  ID_Register_File_Enable;
  logic                  ID_load_instr;
  logic                  ID_valid;
  logic                  IF_ID_LE;
  logic                  flush;
  logic [REG_ADDR_W-1:0] EX_RD, MEM_RD, WB_RD;
  logic                  EX_Register_File_Enable;
  logic                  MEM_Register_File_Enable;
  logic                  WB_Register_File_Enable;
  logic                  EX_load_instr;
  logic                  stall_timeout;
  logic                  protocol_err;
`ifdef DTP_PERF_COUNTERS_EN
  logic [31:0]           bubble_count;
  logic [31:0]           retire_count;
`endif

  dest_tracking_pipeline dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .ID_RD                    (ID_RD),
    .ID_Register_File_Enable  (ID_Register_File_Enable),
    .ID_load_instr            (ID_load_instr),
    .ID_valid                 (ID_valid),
    .IF_ID_LE                 (IF_ID_LE),
    .flush                    (flush),
    .EX_RD                    (EX_RD),
    .MEM_RD                   (MEM_RD),
    .WB_RD                    (WB_RD),
    .EX_Register_File_Enable  (EX_Register_File_Enable),
    .MEM_Register_File_Enable (MEM_Register_File_Enable),
    .WB_Register_File_Enable  (WB_Register_File_Enable),
    .EX_load_instr            (EX_load_instr),
    .stall_timeout            (stall_timeout),
    .protocol_err             (protocol_err)
`ifdef DTP_PERF_COUNTERS_EN
    ,
    .bubble_count             (bubble_count),
    .retire_count             (retire_count)
`endif
  );

  // scoreboard: expected EX entries {rd, rf_en, load}, oldest first
  localparam int W = REG_ADDR_W + 2;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic [REG_ADDR_W-1:0] rd, input logic en, input logic ld);
    return {rd, en, ld};
  endfunction

  task automatic check_stages(input string tag);
    int n;
    logic [W-1:0] e_ex, e_mem, e_wb;
    n     = exp_q.size();
    e_ex  = exp_q[n-1];
    e_mem = exp_q[n-2];
    e_wb  = exp_q[n-3];
    check({tag, "_ex"},  {EX_RD, EX_Register_File_Enable, EX_load_instr}, e_ex);
    check({tag, "_mem"}, {MEM_RD, MEM_Register_File_Enable}, e_mem[W-1:1]);
    check({tag, "_wb"},  {WB_RD, WB_Register_File_Enable}, e_wb[W-1:1]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},    {EX_RD, MEM_RD, WB_RD}, '0);
    check({tag, "_en"},    {EX_Register_File_Enable, MEM_Register_File_Enable,
                            WB_Register_File_Enable, EX_load_instr}, '0);
    check({tag, "_flags"}, {stall_timeout, protocol_err}, '0);
  endtask

  // driver: present ID inputs, take one edge, check against hand-computed EX entry
  task automatic step(input string tag, input logic [REG_ADDR_W-1:0] rd, input logic en,
                      input logic ld, input logic vld, input logic le, input logic fl,
                      input logic [W-1:0] exp_ex);
    ID_RD                   = rd;
    ID_Register_File_Enable = en;
    ID_load_instr           = ld;
    ID_valid                = vld;
    IF_ID_LE                = le;
    flush                   = fl;
    exp_q.push_back(exp_ex);
    @(posedge clk);
    #1;
    check_stages(tag);
  endtask

  task automatic reset_model();
    exp_q.delete();
    repeat (3) exp_q.push_back('0);
  endtask

  initial begin
    rst_n = 1'b0;
    step_inputs_idle();
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // r5 held: EX at cycle 1, MEM at 2, WB at 3
    step("r5_c1", 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd5, 1'b1, 1'b0));
    step("r5_c2", 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd5, 1'b1, 1'b0));
    step("r5_c3", 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd5, 1'b1, 1'b0));
    // $zero write: enable stripped
    step("r0",    5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd0, 1'b0, 1'b0));
    step("r3_ne", 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd3, 1'b0, 1'b0));
    step("r7",    5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd7, 1'b1, 1'b0));

    // load r8 then a one-cycle load-use stall
    step("ld8",   5'd8,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pk(5'd8, 1'b1, 1'b1));
    step("stall", 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(5'd0, 1'b0, 1'b0));
    check("stall_flags", {stall_timeout, protocol_err}, 2'b00);
    step("r10",   5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd10, 1'b1, 1'b0));

    // flush squashes r9; r9 must never reach MEM/WB
    step("flush9", 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, pk(5'd0, 1'b0, 1'b0));
    step("inval",  5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, pk(5'd0, 1'b0, 1'b0));
    step("r11",    5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd11, 1'b1, 1'b0));
    check("flush_flags", {stall_timeout, protocol_err}, 2'b00);

    // four stalls with no load in EX; first one also carries a flush
    step("pst1", 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, pk(5'd0, 1'b0, 1'b0));
    check("pst1_flags", {stall_timeout, protocol_err}, 2'b01);
    step("pst2", 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(5'd0, 1'b0, 1'b0));
    step("pst3", 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(5'd0, 1'b0, 1'b0));
    check("pst3_flags", {stall_timeout, protocol_err}, 2'b01);
    step("pst4", 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pk(5'd0, 1'b0, 1'b0));
    check("pst4_flags", {stall_timeout, protocol_err}, 2'b11);
    step("r13",  5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd13, 1'b1, 1'b0));
    check("sticky_flags", {stall_timeout, protocol_err}, 2'b11);

    // three entries in flight, then asynchronous reset mid-cycle
    step("f1", 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd1, 1'b1, 1'b0));
    step("f2", 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd2, 1'b1, 1'b0));
    step("f3", 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pk(5'd3, 1'b1, 1'b1));
    #2;
    step_inputs_idle();
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    reset_model();
    #1;
    rst_n = 1'b1;
    step("post_rst", 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pk(5'd4, 1'b1, 1'b0));
    check("post_rst_flags", {stall_timeout, protocol_err}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  task automatic step_inputs_idle();
    ID_RD                   = '0;
    ID_Register_File_Enable = 1'b0;
    ID_load_instr           = 1'b0;
    ID_valid                = 1'b0;
    IF_ID_LE                = 1'b1;
    flush                   = 1'b0;
  endtask

endmodule
